branch_redirect: RTL and testbench

- Sits directly downstream of the combinational branch unit in the SH-4 execute stage.
- Consumes the branch unit's taken/target/delay-slot/PR-write results and sequences the fetch redirect.
- Holds delayed-branch targets until the delay-slot instruction retires.
- Generates the younger-instruction flush and the PR write (return address) for BSR/BSRF/JSR.

---
 rtl/branch_redirect_pkg.sv | 13 +
 rtl/branch_redirect.sv | 131 +++++++++++++
 tb/tb_branch_redirect.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_redirect_pkg.sv
// Shared definitions for the execute-stage branch redirect sequencer:
// state encoding and the default PR return-address offset.
package branch_redirect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLOT  = 2'd1,
    ST_REDIR = 2'd2
  } br_state_e;

  localparam int BR_PR_OFFSET = 4;

endpackage

// File: rtl/branch_redirect.sv
// Branch redirect sequencer: turns branch-unit results into fetch redirects,
// younger-instruction flushes and PR writes. Optional: SLOT_ILLEGAL_CHK_EN.
module branch_redirect
  import branch_redirect_pkg::*;
#(
  parameter int AW        = 32,
  parameter int PR_OFFSET = BR_PR_OFFSET
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          br_valid,
  output logic          br_ready,
  input  logic [AW-1:0] br_pc,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          br_delayslot,
  input  logic          br_write_pr,
  input  logic          slot_retire,
  input  logic          exc_flush,
  output logic          fe_redir_valid,
  input  logic          fe_redir_ready,
  output logic [AW-1:0] fe_redir_target,
  output logic          flush_younger,
  output logic          pr_wen,
  output logic [AW-1:0] pr_wdata,
  output logic          addr_err
`ifdef SLOT_ILLEGAL_CHK_EN
  ,
  output logic          slot_illegal
`endif
);

  br_state_e     state, state_nxt;
  logic [AW-1:0] target_q, target_nxt;
  logic [AW-1:0] pr_wdata_nxt;
  logic          flush_nxt, pr_wen_nxt, addr_err_nxt;
`ifdef SLOT_ILLEGAL_CHK_EN
  logic          illegal_nxt;

  // A branch in the delay slot must reach us so it can be flagged.
  assign br_ready = (state == ST_IDLE) || (state == ST_SLOT);
`else
  assign br_ready = (state == ST_IDLE);
`endif

  assign fe_redir_target = target_q;

  always_comb begin
    state_nxt    = state;
    target_nxt   = target_q;
    pr_wdata_nxt = pr_wdata;
    flush_nxt    = 1'b0;
    pr_wen_nxt   = 1'b0;
    addr_err_nxt = 1'b0;
`ifdef SLOT_ILLEGAL_CHK_EN
    illegal_nxt  = 1'b0;
`endif
    if (exc_flush) begin
      // Exception wins over everything, including a same-cycle accept.
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (br_valid) begin
            if (br_write_pr) begin
              pr_wen_nxt   = 1'b1;
              pr_wdata_nxt = br_pc + AW'(PR_OFFSET);
            end
            if (br_taken) begin
              if (br_target[0]) begin
                addr_err_nxt = 1'b1;
              end else begin
                target_nxt = br_target;
                if (br_delayslot) begin
                  state_nxt = ST_SLOT;
                end else begin
                  flush_nxt = 1'b1;
                  state_nxt = ST_REDIR;
                end
              end
            end
          end
        end
        ST_SLOT: begin
`ifdef SLOT_ILLEGAL_CHK_EN
          if (br_valid) begin
            illegal_nxt = 1'b1;
            state_nxt   = ST_IDLE;
          end else
`endif
          if (slot_retire) begin
            // The slot itself has retired; only what follows it is killed.
            flush_nxt = 1'b1;
            state_nxt = ST_REDIR;
          end
        end
        ST_REDIR: begin
          if (fe_redir_ready) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      target_q       <= '0;
      fe_redir_valid <= 1'b0;
      flush_younger  <= 1'b0;
      pr_wen         <= 1'b0;
      pr_wdata       <= '0;
      addr_err       <= 1'b0;
`ifdef SLOT_ILLEGAL_CHK_EN
      slot_illegal   <= 1'b0;
`endif
    end else begin
      state          <= state_nxt;
      target_q       <= target_nxt;
      fe_redir_valid <= (state_nxt == ST_REDIR);
      flush_younger  <= flush_nxt;
      pr_wen         <= pr_wen_nxt;
      pr_wdata       <= pr_wdata_nxt;
      addr_err       <= addr_err_nxt;
`ifdef SLOT_ILLEGAL_CHK_EN
      slot_illegal   <= illegal_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_branch_redirect.sv
// Directed self-checking bench for branch_redirect; covers the
// SLOT_ILLEGAL_CHK_EN variant when that macro is defined.
module tb_branch_redirect;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid, br_ready, br_taken, br_delayslot, br_write_pr;
  logic [31:0] br_pc, br_target;
  logic        slot_retire, exc_flush;
  logic        fe_redir_valid, fe_redir_ready;
  logic [31:0] fe_redir_target, pr_wdata;
  logic        flush_younger, pr_wen, addr_err;
`ifdef SLOT_ILLEGAL_CHK_EN
  logic        slot_illegal;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_redirect #(.AW(32), .PR_OFFSET(4)) dut (
    .clk(clk), .rst(rst),
    .br_valid(br_valid), .br_ready(br_ready), .br_pc(br_pc),
    .br_taken(br_taken), .br_target(br_target), .br_delayslot(br_delayslot),
    .br_write_pr(br_write_pr), .slot_retire(slot_retire), .exc_flush(exc_flush),
    .fe_redir_valid(fe_redir_valid), .fe_redir_ready(fe_redir_ready),
    .fe_redir_target(fe_redir_target), .flush_younger(flush_younger),
    .pr_wen(pr_wen), .pr_wdata(pr_wdata), .addr_err(addr_err)
`ifdef SLOT_ILLEGAL_CHK_EN
    , .slot_illegal(slot_illegal)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    br_valid = 0; br_taken = 0; br_delayslot = 0; br_write_pr = 0;
    br_pc = '0; br_target = '0; slot_retire = 0; exc_flush = 0;
  endtask

  task automatic drive_br(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic tk, input logic ds, input logic wpr);
    br_valid = 1; br_pc = pc; br_target = tgt;
    br_taken = tk; br_delayslot = ds; br_write_pr = wpr;
  endtask

  task automatic test_reset;
    idle_inputs();
    fe_redir_ready = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL reset_br_ready got %b want 1", br_ready); end
    checks++; if (fe_redir_valid !== 1'b0) begin errors++; $display("FAIL reset_redir_valid got %b want 0", fe_redir_valid); end
    checks++; if (fe_redir_target !== 32'h0) begin errors++; $display("FAIL reset_target got %h want 0", fe_redir_target); end
    checks++; if ({flush_younger, pr_wen, addr_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {flush_younger, pr_wen, addr_err}); end
    checks++; if (pr_wdata !== 32'h0) begin errors++; $display("FAIL reset_pr_wdata got %h want 0", pr_wdata); end
  endtask

  task automatic test_not_taken;
    drive_br(32'h8C000010, 32'h8C000080, 0, 0, 0);
    tick();
    idle_inputs();
    checks++; if ({fe_redir_valid, flush_younger, pr_wen} !== 3'b000) begin errors++; $display("FAIL bf_outputs got %b want 000", {fe_redir_valid, flush_younger, pr_wen}); end
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL bf_ready got %b want 1", br_ready); end
    tick();
    checks++; if (fe_redir_valid !== 1'b0) begin errors++; $display("FAIL bf_later_valid got %b want 0", fe_redir_valid); end
  endtask

  task automatic test_taken_noslot;
    fe_redir_ready = 1;
    drive_br(32'h8C000020, 32'h8C001000, 1, 0, 0);
    tick();
    idle_inputs();
    checks++; if ({flush_younger, fe_redir_valid} !== 2'b11) begin errors++; $display("FAIL bt_flush_valid got %b want 11", {flush_younger, fe_redir_valid}); end
    checks++; if (fe_redir_target !== 32'h8C001000) begin errors++; $display("FAIL bt_target got %h want 8c001000", fe_redir_target); end
    checks++; if (br_ready !== 1'b0) begin errors++; $display("FAIL bt_ready_redir got %b want 0", br_ready); end
    tick();
    checks++; if ({flush_younger, fe_redir_valid, br_ready} !== 3'b001) begin errors++; $display("FAIL bt_back_idle got %b want 001", {flush_younger, fe_redir_valid, br_ready}); end
    fe_redir_ready = 0;
  endtask

  task automatic test_bsr;
    drive_br(32'h8C000100, 32'h8C000200, 1, 1, 1);
    slot_retire = 1;  // same-cycle retire must be ignored
    tick();
    idle_inputs();
    checks++; if (pr_wen !== 1'b1) begin errors++; $display("FAIL bsr_pr_wen got %b want 1", pr_wen); end
    checks++; if (pr_wdata !== 32'h8C000104) begin errors++; $display("FAIL bsr_pr_wdata got %h want 8c000104", pr_wdata); end
    checks++; if ({fe_redir_valid, flush_younger} !== 2'b00) begin errors++; $display("FAIL bsr_no_early_redir got %b want 00", {fe_redir_valid, flush_younger}); end
`ifndef SLOT_ILLEGAL_CHK_EN
    checks++; if (br_ready !== 1'b0) begin errors++; $display("FAIL bsr_slot_stall got %b want 0", br_ready); end
`endif
    tick();
    checks++; if ({pr_wen, fe_redir_valid, flush_younger} !== 3'b000) begin errors++; $display("FAIL bsr_wait1 got %b want 000", {pr_wen, fe_redir_valid, flush_younger}); end
    tick();
    checks++; if ({fe_redir_valid, flush_younger} !== 2'b00) begin errors++; $display("FAIL bsr_wait2 got %b want 00", {fe_redir_valid, flush_younger}); end
    slot_retire = 1;
    tick();
    slot_retire = 0;
    checks++; if ({flush_younger, fe_redir_valid} !== 2'b11) begin errors++; $display("FAIL bsr_redir got %b want 11", {flush_younger, fe_redir_valid}); end
    checks++; if (fe_redir_target !== 32'h8C000200) begin errors++; $display("FAIL bsr_target got %h want 8c000200", fe_redir_target); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({fe_redir_valid, flush_younger} !== 2'b10 || fe_redir_target !== 32'h8C000200) begin errors++; $display("FAIL bsr_hold%0d got v/f %b tgt %h want 10 8c000200", i, {fe_redir_valid, flush_younger}, fe_redir_target); end
    end
    fe_redir_ready = 1;
    tick();
    fe_redir_ready = 0;
    checks++; if ({fe_redir_valid, br_ready} !== 2'b01) begin errors++; $display("FAIL bsr_done got %b want 01", {fe_redir_valid, br_ready}); end
  endtask

  task automatic test_addr_err;
    drive_br(32'h8C000300, 32'h8C000201, 1, 0, 0);
    tick();
    idle_inputs();
    checks++; if ({addr_err, fe_redir_valid, flush_younger} !== 3'b100) begin errors++; $display("FAIL jmp_odd got %b want 100", {addr_err, fe_redir_valid, flush_younger}); end
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL jmp_odd_ready got %b want 1", br_ready); end
    tick();
    checks++; if ({addr_err, fe_redir_valid} !== 2'b00) begin errors++; $display("FAIL jmp_odd_after got %b want 00", {addr_err, fe_redir_valid}); end
  endtask

  task automatic test_exc_flush;
    drive_br(32'h8C000400, 32'h8C000500, 1, 1, 0);
    tick();
    idle_inputs();
    exc_flush = 1;
    tick();
    exc_flush = 0;
    checks++; if ({br_ready, fe_redir_valid} !== 2'b10) begin errors++; $display("FAIL exc_slot_idle got %b want 10", {br_ready, fe_redir_valid}); end
    slot_retire = 1;
    tick();
    slot_retire = 0;
    checks++; if ({fe_redir_valid, flush_younger} !== 2'b00) begin errors++; $display("FAIL exc_no_redir got %b want 00", {fe_redir_valid, flush_younger}); end
    // exception in the same cycle as an accept suppresses its pulses
    drive_br(32'h8C000600, 32'h8C000701, 1, 0, 1);
    exc_flush = 1;
    tick();
    idle_inputs();
    checks++; if ({pr_wen, addr_err, fe_redir_valid} !== 3'b000) begin errors++; $display("FAIL exc_same_cycle got %b want 000", {pr_wen, addr_err, fe_redir_valid}); end
    // exception while the redirect is pending drops it
    drive_br(32'h8C000800, 32'h8C000900, 1, 0, 0);
    tick();
    idle_inputs();
    exc_flush = 1;
    tick();
    exc_flush = 0;
    checks++; if ({fe_redir_valid, br_ready} !== 2'b01) begin errors++; $display("FAIL exc_redir_drop got %b want 01", {fe_redir_valid, br_ready}); end
  endtask

  task automatic test_pr_wrap;
    drive_br(32'hFFFFFFFC, 32'h8C000A00, 1, 1, 1);
    tick();
    idle_inputs();
    checks++; if (pr_wen !== 1'b1 || pr_wdata !== 32'h0) begin errors++; $display("FAIL bsrf_wrap got wen %b data %h want 1 00000000", pr_wen, pr_wdata); end
    exc_flush = 1;
    tick();
    exc_flush = 0;
    checks++; if (pr_wdata !== 32'h0) begin errors++; $display("FAIL bsrf_pr_kept got %h want 0", pr_wdata); end
    // not-taken branch still writes PR
    drive_br(32'h00000100, 32'h00000200, 0, 0, 1);
    tick();
    idle_inputs();
    checks++; if (pr_wen !== 1'b1 || pr_wdata !== 32'h104 || fe_redir_valid !== 1'b0) begin errors++; $display("FAIL pr_not_taken got wen %b data %h v %b want 1 00000104 0", pr_wen, pr_wdata, fe_redir_valid); end
  endtask

  task automatic test_rst_mid;
    drive_br(32'h8C000B00, 32'h8C000C00, 1, 0, 0);
    tick();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    checks++; if ({fe_redir_valid, br_ready} !== 2'b01 || fe_redir_target !== 32'h0) begin errors++; $display("FAIL rst_mid got v/r %b tgt %h want 01 0", {fe_redir_valid, br_ready}, fe_redir_target); end
    fe_redir_ready = 1;
    tick();
    fe_redir_ready = 0;
    checks++; if (fe_redir_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_after got %b want 0", fe_redir_valid); end
  endtask

`ifdef SLOT_ILLEGAL_CHK_EN
  task automatic test_slot_illegal;
    drive_br(32'h8C000D00, 32'h8C000E00, 1, 1, 0);
    tick();
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL ill_ready_slot got %b want 1", br_ready); end
    drive_br(32'h8C000D02, 32'h8C000F00, 1, 0, 0);
    tick();
    idle_inputs();
    checks++; if ({slot_illegal, fe_redir_valid, flush_younger} !== 3'b100) begin errors++; $display("FAIL ill_pulse got %b want 100", {slot_illegal, fe_redir_valid, flush_younger}); end
    slot_retire = 1;
    tick();
    slot_retire = 0;
    checks++; if ({slot_illegal, fe_redir_valid, flush_younger} !== 3'b000) begin errors++; $display("FAIL ill_dropped got %b want 000", {slot_illegal, fe_redir_valid, flush_younger}); end
  endtask
`endif

  initial begin
    test_reset();
    test_not_taken();
    test_taken_noslot();
    test_bsr();
    test_addr_err();
    test_exc_flush();
    test_pr_wrap();
    test_rst_mid();
`ifdef SLOT_ILLEGAL_CHK_EN
    test_slot_illegal();
`endif
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
